ccd_line_capture: RTL and testbench
===================================

# ccd_line_capture

Parametrised linear-CCD line acquisition engine: generates SI/CCD/ADC clocks for an N-pixel linear sensor, captures one line of ADC samples into an internal line buffer, then streams the line out over a valid/ready interface with optional threshold binarisation and per-line min/max statistics. Sits between the sensor/ADC pins and the UART/processing path, replacing the fixed 128-pixel drive + FIFO pairing with a single block supporting single-shot and continuous modes and downstream backpressure.

## Interface
- PIX_NUM, 128: pixels per line (≥2).
- AD_WIDTH, 8: ADC sample width.
- CLK_DIV, 25: sys_clk cycles per CCD clock half-period (≥1).
- ADC_LAT, 1: ADC pipeline delay in CCD periods (≥1).
- INT_CYCLES, 1000: minimum sys_clk cycles from end of one capture to next SI in continuous mode.

- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: capture one line.
- cont  in  1  continuous capture when high.
- bin_en  in  1  binarise output when high.
- threshold  in  AD_WIDTH  binarisation threshold.
- ad_data  in  AD_WIDTH  ADC sample.
- ad_clk  out  1  ADC clock, equal to ccdclk.
- ccdclk  out  1  sensor pixel clock.
- si  out  1  sensor start-integration pulse.
- m_data  out  AD_WIDTH  pixel output.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high with pixel PIX_NUM-1.
- busy  out  1  high outside IDLE.
- overrun  out  1  one-cycle pulse: start ignored.
- line_max, line_min  out  AD_WIDTH each  raw statistics of last captured line.
- stats_valid  out  1  one-cycle pulse when line_max/line_min update.

## Operation
- States: IDLE, SHIFT, STREAM, WAIT_INT.
- IDLE → SHIFT on start, or on cont when the integration counter has expired (always true after reset). bin_en/threshold latched on this transition for the whole line.
- SHIFT: PIX_NUM+ADC_LAT CCD periods p=0..PIX_NUM+ADC_LAT-1; each period is 2·CLK_DIV cycles, ccdclk low for the first CLK_DIV, high for the second. si high for all of period 0, low otherwise. Total rising edges of ccdclk = PIX_NUM+ADC_LAT (≥ PIX_NUM+1, satisfying the sensor's extra clock).
- Sampling: on the last cycle of the high half of period p, if p ≥ ADC_LAT, ad_data is written to buffer[p-ADC_LAT] and folded into running max/min.
- End of SHIFT: line_max/line_min registered, stats_valid pulses, go to STREAM; integration counter starts (counts INT_CYCLES).
- STREAM: emit buffer[0..PIX_NUM-1] in order. Output value = bin_en ? (pix ≥ threshold ? all-ones : 0) : pix. m_last with index PIX_NUM-1. After last handshake → WAIT_INT if cont, else IDLE.
- WAIT_INT: stay until integration counter expired, then SHIFT if cont still high, else IDLE.
- start while busy: ignored, overrun pulses one cycle. start in IDLE with cont high: one capture, no overrun.
- cont dropped mid-line: current line completes and streams fully.
- Buffer is single-ported-per-side RAM, depth PIX_NUM; no capture begins until STREAM finishes (backpressure stretches integration time).

## Timing
- Reset values: si, ccdclk, ad_clk, m_valid, m_last, busy, overrun, stats_valid = 0; m_data, line_max, line_min = 0; state IDLE, counter expired.
- si/ccdclk first change the cycle after the start pulse is sampled; busy rises the same cycle.
- SHIFT lasts exactly (PIX_NUM+ADC_LAT)·2·CLK_DIV cycles.
- m_valid first asserts ≤2 cycles after entering STREAM; then one pixel per cycle while m_ready high.
- Standard valid/ready: m_data/m_last stable while m_valid & !m_ready; m_valid never drops without a handshake.
- Reset asserted mid-operation: all outputs to reset values immediately; partial line discarded.

## Test plan
- PIX_NUM=8, CLK_DIV=2, ADC_LAT=1; bench drives ad_data=16+k during period k+1; single start, m_ready=1 → si high exactly 4 cycles, 9 ccdclk rising edges, stream 16..23, m_last on 23, line_max=23, line_min=16, stats_valid one pulse.
- Same, m_ready toggling 1/0 each cycle → identical sequence, m_data stable during stalls, 8 handshakes exactly.
- bin_en=1, threshold=20 → 0,0,0,0,FF,FF,FF,FF; stats still 23/16.
- start pulse during SHIFT → overrun one-cycle pulse, only one line streamed.
- cont=1, INT_CYCLES=10, m_ready=1 → successive si rises spaced ≥ SHIFT+STREAM duration; m_ready held 0 for 100 cycles → next si delayed until stream completes.
- Reset pulsed mid-SHIFT → outputs at reset values immediately; subsequent start yields clean 16..23 line.

Source files
------------

// File: rtl/ccd_line_capture_if.sv
// Pixel stream port of the linear-CCD line capture engine.
// Standard valid/ready: the master holds data/last until a handshake completes.
interface ccd_line_capture_if #(
    parameter int AD_WIDTH = 8
) ();
    logic [AD_WIDTH-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (output m_data, output m_valid, output m_last, input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

// File: rtl/ccd_line_capture.sv
// Linear-CCD line acquisition: drives SI/CCD/ADC clocks, captures one line into a
// buffer, then streams it with optional binarisation and per-line min/max.
module ccd_line_capture #(
    parameter int PIX_NUM    = 128,
    parameter int AD_WIDTH   = 8,
    parameter int CLK_DIV    = 25,
    parameter int ADC_LAT    = 1,
    parameter int INT_CYCLES = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic                bin_en,
    input  logic [AD_WIDTH-1:0] threshold,
    input  logic [AD_WIDTH-1:0] ad_data,
    output logic                ad_clk,
    output logic                ccdclk,
    output logic                si,
    ccd_line_capture_if.master  m_if,
    output logic                busy,
    output logic                overrun,
    output logic [AD_WIDTH-1:0] line_max,
    output logic [AD_WIDTH-1:0] line_min,
    output logic                stats_valid
);
    localparam int PERIODS = PIX_NUM + ADC_LAT;
    localparam int PW      = $clog2(PERIODS);
    localparam int DW      = $clog2(2 * CLK_DIV);
    localparam int IW      = $clog2(PIX_NUM);
    localparam int RW      = $clog2(PIX_NUM + 1);
    localparam int ICW     = (INT_CYCLES > 0) ? $clog2(INT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, STREAM, WAIT_INT} state_t;

    state_t              state, state_n;
    logic [DW-1:0]       div_cnt;
    logic [PW-1:0]       per_cnt;
    logic [ICW-1:0]      int_cnt;
    logic [RW-1:0]       rd_idx;
    logic [AD_WIDTH-1:0] run_max, run_min, smp_max, smp_min;
    logic [AD_WIDTH-1:0] thr_q, pix, pix_out;
    logic                bin_q;
    logic [IW-1:0]       wr_addr, rd_addr;
    logic [AD_WIDTH-1:0] line_buf [PIX_NUM];

    logic half_end, per_last, shift_done, sample, first_smp;
    logic int_exp, stream_done, enter_shift;

    assign half_end    = div_cnt == DW'(2 * CLK_DIV - 1);
    assign per_last    = per_cnt == PW'(PERIODS - 1);
    assign shift_done  = (state == SHIFT) && half_end && per_last;
    assign sample      = (state == SHIFT) && half_end && (per_cnt >= PW'(ADC_LAT));
    assign first_smp   = per_cnt == PW'(ADC_LAT);
    assign int_exp     = int_cnt == '0;
    assign stream_done = (state == STREAM) && m_if.m_valid && m_if.m_ready && m_if.m_last;
    assign enter_shift = (state_n == SHIFT) && (state != SHIFT);

    // Sensor pins decode straight from the period/phase counters.
    assign si     = (state == SHIFT) && (per_cnt == '0);
    assign ccdclk = (state == SHIFT) && (div_cnt >= DW'(CLK_DIV));
    assign ad_clk = ccdclk;
    assign busy   = state != IDLE;

    assign wr_addr = IW'(per_cnt - PW'(ADC_LAT));
    assign rd_addr = IW'(rd_idx);
    assign pix     = line_buf[rd_addr];
    assign pix_out = bin_q ? {AD_WIDTH{pix >= thr_q}} : pix;

    assign smp_max = (first_smp || ad_data > run_max) ? ad_data : run_max;
    assign smp_min = (first_smp || ad_data < run_min) ? ad_data : run_min;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start || (cont && int_exp)) state_n = SHIFT;
            SHIFT:    if (shift_done)                 state_n = STREAM;
            STREAM:   if (stream_done)                state_n = cont ? WAIT_INT : IDLE;
            WAIT_INT: if (int_exp)                    state_n = cont ? SHIFT : IDLE;
            default:                                  state_n = IDLE;
        endcase
    end

    // Buffer has no reset; a discarded partial line is simply overwritten.
    always_ff @(posedge sys_clk) begin
        if (sample) line_buf[wr_addr] <= ad_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt     <= '0;
            per_cnt     <= '0;
            int_cnt     <= '0;
            rd_idx      <= '0;
            run_max     <= '0;
            run_min     <= '0;
            line_max    <= '0;
            line_min    <= '0;
            stats_valid <= 1'b0;
            overrun     <= 1'b0;
            bin_q       <= 1'b0;
            thr_q       <= '0;
            m_if.m_data  <= '0;
            m_if.m_valid <= 1'b0;
            m_if.m_last  <= 1'b0;
        end else begin
            overrun     <= start && (state != IDLE);
            stats_valid <= shift_done;

            if (enter_shift) begin
                div_cnt <= '0;
                per_cnt <= '0;
                bin_q   <= bin_en;
                thr_q   <= threshold;
            end else if (state == SHIFT) begin
                div_cnt <= half_end ? '0 : div_cnt + DW'(1);
                if (half_end && !per_last) per_cnt <= per_cnt + PW'(1);
            end

            if (sample) begin
                run_max <= smp_max;
                run_min <= smp_min;
            end

            // Integration time runs from the end of capture, overlapping the stream.
            if (shift_done) begin
                line_max <= smp_max;
                line_min <= smp_min;
                int_cnt  <= ICW'(INT_CYCLES);
                rd_idx   <= '0;
            end else if (!int_exp) begin
                int_cnt <= int_cnt - ICW'(1);
            end

            if (state == STREAM) begin
                if ((!m_if.m_valid || m_if.m_ready) && rd_idx != RW'(PIX_NUM)) begin
                    m_if.m_data  <= pix_out;
                    m_if.m_valid <= 1'b1;
                    m_if.m_last  <= rd_idx == RW'(PIX_NUM - 1);
                    rd_idx       <= rd_idx + RW'(1);
                end else if (m_if.m_ready) begin
                    m_if.m_valid <= 1'b0;
                    m_if.m_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccd_line_capture.sv
// Directed bench for ccd_line_capture: 8-pixel sensor model feeding 16+k per pixel.
module tb_ccd_line_capture;
    localparam int PIX = 8, ADW = 8, CD = 2, LAT = 1, INTC = 10;
    localparam int SHIFT_CYC = (PIX + LAT) * 2 * CD;

    logic           sys_clk = 0, sys_rst_n = 0;
    logic           start = 0, cont = 0, bin_en = 0;
    logic [ADW-1:0] threshold = 0, ad_data = 0;
    logic           ad_clk, ccdclk, si, busy, overrun, stats_valid;
    logic [ADW-1:0] line_max, line_min;

    ccd_line_capture_if #(.AD_WIDTH(ADW)) mif ();

    ccd_line_capture #(.PIX_NUM(PIX), .AD_WIDTH(ADW), .CLK_DIV(CD), .ADC_LAT(LAT),
                       .INT_CYCLES(INTC)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .cont(cont),
        .bin_en(bin_en), .threshold(threshold), .ad_data(ad_data), .ad_clk(ad_clk),
        .ccdclk(ccdclk), .si(si), .m_if(mif.master), .busy(busy), .overrun(overrun),
        .line_max(line_max), .line_min(line_min), .stats_valid(stats_valid));

    always #5 sys_clk = ~sys_clk;

    int total = 0, bad = 0;

    bit   rdy_tog = 0;
    logic rdy_lvl = 0;
    always @(posedge sys_clk) begin
        #2;
        mif.m_ready = rdy_tog ? ~mif.m_ready : rdy_lvl;
    end

    int cyc = 0, ccd_n = 0, hs_n = 0, sv_n = 0, ov_n = 0, stall_err = 0, si_hi_n = 0;
    int line_edge = 0, vld_rise_cyc = 0, sv_cyc = 0, last_hs_cyc = 0, last_n = 0;
    logic [ADW-1:0] hs_q[$];
    bit             hs_l_q[$];
    int             si_rise_q[$];
    logic si_p = 0, ccd_p = 0, vld_p = 0, stall_p = 0, l_p = 0;
    logic [ADW-1:0] d_p = 0, st_max = 0, st_min = 0;

    // Monitor plus sensor model: sample between edges, present 16+k in period k+1.
    always @(negedge sys_clk) begin
        cyc++;
        if (si) si_hi_n++;
        if (si && !si_p) begin si_rise_q.push_back(cyc); line_edge = 0; end
        if (ccdclk && !ccd_p) begin ccd_n++; line_edge++; ad_data = 8'(14 + line_edge); end
        if (mif.m_valid && !vld_p) vld_rise_cyc = cyc;
        if (sys_rst_n && stall_p && (!mif.m_valid || mif.m_data !== d_p || mif.m_last !== l_p))
            stall_err++;
        if (mif.m_valid && mif.m_ready) begin
            hs_q.push_back(mif.m_data);
            hs_l_q.push_back(mif.m_last);
            hs_n++;
            if (mif.m_last) begin last_n++; last_hs_cyc = cyc; end
        end
        if (stats_valid) begin sv_n++; sv_cyc = cyc; st_max = line_max; st_min = line_min; end
        if (overrun) ov_n++;
        si_p = si; ccd_p = ccdclk; vld_p = mif.m_valid;
        stall_p = mif.m_valid && !mif.m_ready; d_p = mif.m_data; l_p = mif.m_last;
    end

    task automatic pulse_start();
        @(posedge sys_clk); #2 start = 1;
        @(posedge sys_clk); #2 start = 0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge sys_clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        total++;
        if ({si, ccdclk, ad_clk, mif.m_valid, mif.m_last, busy, overrun, stats_valid} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000000",
                {si, ccdclk, ad_clk, mif.m_valid, mif.m_last, busy, overrun, stats_valid});
        end
        total++;
        if ({mif.m_data, line_max, line_min} !== 24'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=000000", {mif.m_data, line_max, line_min});
        end
        @(posedge sys_clk); #2 sys_rst_n = 1; rdy_lvl = 1;
        repeat (3) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", busy); end
    endtask

    task automatic test_line(input string tag, input bit bin, input logic [ADW-1:0] thr, input bit tog);
        int q0 = hs_q.size(), c0 = ccd_n, s0 = si_hi_n, v0 = sv_n, o0 = ov_n, e0 = stall_err;
        int r0 = si_rise_q.size();
        bit ok;
        logic [ADW-1:0] exp;
        bin_en = bin; threshold = thr; rdy_lvl = 1; rdy_tog = tog;
        pulse_start();
        @(negedge sys_clk);
        total++;
        if ({busy, si} !== 2'b11) begin bad++; $display("FAIL %s busy_si got=%b exp=11", tag, {busy, si}); end
        wait_idle(600, ok);
        rdy_tog = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL %s timeout got=busy exp=idle", tag); end
        total++;
        if (si_hi_n - s0 != 4) begin bad++; $display("FAIL %s si_cycles got=%0d exp=4", tag, si_hi_n - s0); end
        total++;
        if (ccd_n - c0 != PIX + LAT) begin bad++; $display("FAIL %s ccd_rises got=%0d exp=%0d", tag, ccd_n - c0, PIX + LAT); end
        total++;
        if (hs_q.size() - q0 != PIX) begin bad++; $display("FAIL %s handshakes got=%0d exp=%0d", tag, hs_q.size() - q0, PIX); end
        total++;
        if (sv_n - v0 != 1) begin bad++; $display("FAIL %s stats_pulses got=%0d exp=1", tag, sv_n - v0); end
        total++;
        if (ov_n - o0 != 0) begin bad++; $display("FAIL %s overrun got=%0d exp=0", tag, ov_n - o0); end
        total++;
        if (stall_err - e0 != 0) begin bad++; $display("FAIL %s stall_stable got=%0d exp=0", tag, stall_err - e0); end
        total++;
        if (si_rise_q.size() > r0 && sv_cyc - si_rise_q[r0] != SHIFT_CYC) begin
            bad++; $display("FAIL %s shift_len got=%0d exp=%0d", tag, sv_cyc - si_rise_q[r0], SHIFT_CYC);
        end
        total++;
        if (vld_rise_cyc - sv_cyc < 1 || vld_rise_cyc - sv_cyc > 2) begin
            bad++; $display("FAIL %s valid_latency got=%0d exp=1..2", tag, vld_rise_cyc - sv_cyc);
        end
        total++;
        if ({st_max, st_min} !== {8'd23, 8'd16}) begin
            bad++; $display("FAIL %s stats got=%0d/%0d exp=23/16", tag, st_max, st_min);
        end
        if (hs_q.size() >= q0 + PIX) begin
            for (int i = 0; i < PIX; i++) begin
                exp = bin ? ((16 + i >= thr) ? 8'hFF : 8'h00) : 8'(16 + i);
                total++;
                if (hs_q[q0+i] !== exp || hs_l_q[q0+i] !== (i == PIX - 1)) begin
                    bad++; $display("FAIL %s pix%0d got=%0h/%0b exp=%0h/%0b", tag, i,
                        hs_q[q0+i], hs_l_q[q0+i], exp, i == PIX - 1);
                end
            end
        end
        bin_en = 0;
    endtask

    task automatic test_overrun();
        int q0 = hs_q.size(), o0 = ov_n, r0 = si_rise_q.size();
        bit ok;
        pulse_start();
        repeat (10) @(negedge sys_clk);
        pulse_start();
        wait_idle(600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ovr_timeout got=busy exp=idle"); end
        total++;
        if (ov_n - o0 != 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ov_n - o0); end
        total++;
        if (hs_q.size() - q0 != PIX || si_rise_q.size() - r0 != 1) begin
            bad++; $display("FAIL ovr_lines got=%0d/%0d exp=%0d/1", hs_q.size() - q0, si_rise_q.size() - r0, PIX);
        end
    endtask

    task automatic test_cont();
        int q0 = hs_q.size(), l0 = last_n, r0 = si_rise_q.size(), sp;
        bit ok;
        rdy_lvl = 1;
        @(posedge sys_clk); #2 cont = 1;
        for (int i = 0; i < 400 && si_rise_q.size() < r0 + 2; i++) @(negedge sys_clk);
        rdy_lvl = 0;
        total++;
        if (si_rise_q.size() < r0 + 2) begin
            bad++; $display("FAIL cont_second_si got=%0d exp=2", si_rise_q.size() - r0);
        end else begin
            sp = si_rise_q[r0+1] - si_rise_q[r0];
            total++;
            if (sp < SHIFT_CYC + INTC || sp > SHIFT_CYC + INTC + 14) begin
                bad++; $display("FAIL cont_spacing got=%0d exp=%0d..%0d", sp, SHIFT_CYC + INTC, SHIFT_CYC + INTC + 14);
            end
        end
        repeat (150) @(negedge sys_clk);
        total++;
        if (si_rise_q.size() - r0 != 2) begin bad++; $display("FAIL stall_blocks_si got=%0d exp=2", si_rise_q.size() - r0); end
        total++;
        if ({mif.m_valid, mif.m_data} !== {1'b1, 8'd16}) begin
            bad++; $display("FAIL stall_hold got=%b/%0d exp=1/16", mif.m_valid, mif.m_data);
        end
        rdy_lvl = 1;
        for (int i = 0; i < 200 && si_rise_q.size() < r0 + 3; i++) @(negedge sys_clk);
        total++;
        if (si_rise_q.size() < r0 + 3 || si_rise_q[r0+2] <= last_hs_cyc) begin
            bad++; $display("FAIL third_si got=%0d exp=after %0d", si_rise_q.size() - r0, last_hs_cyc);
        end
        @(posedge sys_clk); #2 cont = 0;
        wait_idle(400, ok);
        total++;
        if (!ok || last_n - l0 != 3 || si_rise_q.size() - r0 != 3) begin
            bad++; $display("FAIL cont_drop got=%0d lines exp=3 (idle=%0b)", last_n - l0, ok);
        end
        total++;
        if (hs_q.size() - q0 != 3 * PIX || hs_q[hs_q.size()-1] !== 8'd23) begin
            bad++; $display("FAIL cont_data got=%0d hs exp=%0d", hs_q.size() - q0, 3 * PIX);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        repeat (10) @(negedge sys_clk);
        sys_rst_n = 0;
        #1;
        total++;
        if ({si, ccdclk, ad_clk, busy, mif.m_valid, overrun, stats_valid} !== 7'h0) begin
            bad++; $display("FAIL midreset_ctrl got=%b exp=0000000",
                {si, ccdclk, ad_clk, busy, mif.m_valid, overrun, stats_valid});
        end
        total++;
        if ({line_max, line_min, mif.m_data} !== 24'h0) begin
            bad++; $display("FAIL midreset_data got=%h exp=000000", {line_max, line_min, mif.m_data});
        end
        @(posedge sys_clk); #2 sys_rst_n = 1;
        repeat (2) @(negedge sys_clk);
        test_line("after_reset", 0, 8'd0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line("single", 0, 8'd0, 0);
        test_line("backpressure", 0, 8'd0, 1);
        test_line("binarise", 1, 8'd20, 0);
        test_overrun();
        test_cont();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
